// File: rtl/tile_map_sequencer.sv
// Walks the tile map row-major, turning each valid tile index into a ROM base
// address plus screen origin and handing it to the tile drawer one cell at a time.
module tile_map_sequencer #(
   parameter int MAP_COLS   = 20,
   parameter int MAP_ROWS   = 15,
   parameter int NUM_TILES  = 21,
   parameter int TILE_BYTES = 192
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [8:0]  map_addr,
   input  logic [7:0]  map_data,
   output logic [11:0] tile_address,
   output logic [7:0]  x_pos,
   output logic [7:0]  y_pos,
   output logic        draw,
   input  logic        drawer_active,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_WAIT_DATA = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_ADVANCE   = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   localparam logic [7:0]  LAST_COL     = 8'(MAP_COLS - 1);
   localparam logic [7:0]  LAST_ROW     = 8'(MAP_ROWS - 1);
   localparam logic [7:0]  NUM_TILES_C  = 8'(NUM_TILES);
   localparam logic [11:0] TILE_BYTES_C = 12'(TILE_BYTES);

   state_t      state_q, state_d;
   logic [7:0]  col_q, col_d;
   logic [7:0]  row_q, row_d;
   logic [8:0]  map_addr_q, map_addr_d;
   logic [11:0] tile_address_q, tile_address_d;
   logic [7:0]  x_pos_q, x_pos_d;
   logic [7:0]  y_pos_q, y_pos_d;
   logic        draw_q, draw_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Next-state, cell counters and registered-output precomputation.
   always_comb begin
      state_d        = state_q;
      col_d          = col_q;
      row_d          = row_q;
      map_addr_d     = map_addr_q;
      tile_address_d = tile_address_q;
      x_pos_d        = x_pos_q;
      y_pos_d        = y_pos_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH;
               col_d      = 8'd0;
               row_d      = 8'd0;
               map_addr_d = 9'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: state_d = S_WAIT_DATA;
         S_WAIT_DATA: begin
            // Out-of-range indices (including 8'hFF) are empty cells.
            if (map_data >= NUM_TILES_C) begin
               state_d = S_ADVANCE;
            end else begin
               state_d = S_ISSUE;
               // Constant multiply; for 192 bytes this is (idx<<7)+(idx<<6).
               tile_address_d = {4'd0, map_data} * TILE_BYTES_C;
               x_pos_d        = col_q << 3'd3;
               y_pos_d        = row_q << 3'd3;
            end
         end
         S_ISSUE: begin
            if (drawer_active) begin
               state_d = S_WAIT_DONE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT_DONE: begin
            if (!drawer_active) begin
               state_d = S_ADVANCE;
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         S_ADVANCE: begin
            if ((col_q == LAST_COL) && (row_q == LAST_ROW)) begin
               state_d = S_DONE;
            end else begin
               state_d    = S_FETCH;
               map_addr_d = map_addr_q + 9'd1;
               if (col_q == LAST_COL) begin
                  col_d = 8'd0;
                  row_d = row_q + 8'd1;
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      draw_d = (state_d == S_ISSUE);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         col_q          <= 8'd0;
         row_q          <= 8'd0;
         map_addr_q     <= 9'd0;
         tile_address_q <= 12'd0;
         x_pos_q        <= 8'd0;
         y_pos_q        <= 8'd0;
         draw_q         <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         col_q          <= col_d;
         row_q          <= row_d;
         map_addr_q     <= map_addr_d;
         tile_address_q <= tile_address_d;
         x_pos_q        <= x_pos_d;
         y_pos_q        <= y_pos_d;
         draw_q         <= draw_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign map_addr     = map_addr_q;
   assign tile_address = tile_address_q;
   assign x_pos        = x_pos_q;
   assign y_pos        = y_pos_q;
   assign draw         = draw_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_tile_map_sequencer.sv
// Directed bench: a 2x2 instance driven from a vector table plus hand sequences,
// and a default 20x15 instance walked over a full map.
module tb_tile_map_sequencer;

   logic        clk, reset, start_s, start_f, hold_act;
   logic [8:0]  map_addr_s, map_addr_f;
   logic [7:0]  map_data_s, map_data_f;
   logic [11:0] ta_s, ta_f;
   logic [7:0]  x_s, y_s, x_f, y_f;
   logic        draw_s, draw_f, act_s, act_f, busy_s, busy_f, done_s, done_f;

   tile_map_sequencer #(.MAP_COLS(2), .MAP_ROWS(2)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .map_addr(map_addr_s),
      .map_data(map_data_s), .tile_address(ta_s), .x_pos(x_s), .y_pos(y_s),
      .draw(draw_s), .drawer_active(act_s), .busy(busy_s), .done(done_s));

   tile_map_sequencer dut_f (
      .clk(clk), .reset(reset), .start(start_f), .map_addr(map_addr_f),
      .map_data(map_data_f), .tile_address(ta_f), .x_pos(x_f), .y_pos(y_f),
      .draw(draw_f), .drawer_active(act_f), .busy(busy_f), .done(done_f));

   typedef struct packed {
      logic [3:0][7:0]  idx;      // element [0] is cell 0 (rightmost in concatenations)
      logic [7:0]       a;        // drawer acknowledge latency
      logic [7:0]       l;        // drawer active length
      logic [3:0]       n;        // expected draw count
      logic [3:0][11:0] ta;
      logic [3:0][7:0]  x;
      logic [3:0][7:0]  y;
      logic [3:0][7:0]  rise;     // draw rise, cycles after start sampled
      logic [7:0]       done_off;
   } vec_t;

   vec_t vecs [5];
   logic [7:0] mem_s [4];
   logic [7:0] mem_f [300];
   int ack_lat, act_len;
   int cyc = 0;
   int total = 0;
   int bad = 0;

   int   dr_phase [2] = '{0, 0};
   int   dr_cnt   [2] = '{0, 0};
   logic dr_act   [2] = '{1'b0, 1'b0};

   logic        draw_w [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic [11:0] ta_w   [2];
   logic [7:0]  x_w    [2];
   logic [7:0]  y_w    [2];
   logic [8:0]  ma_w   [2];
   assign draw_w[0] = draw_s;     assign draw_w[1] = draw_f;
   assign busy_w[0] = busy_s;     assign busy_w[1] = busy_f;
   assign done_w[0] = done_s;     assign done_w[1] = done_f;
   assign ta_w[0]   = ta_s;       assign ta_w[1]   = ta_f;
   assign x_w[0]    = x_s;        assign x_w[1]    = x_f;
   assign y_w[0]    = y_s;        assign y_w[1]    = y_f;
   assign ma_w[0]   = map_addr_s; assign ma_w[1]   = map_addr_f;
   assign act_s = dr_act[0] | hold_act;
   assign act_f = dr_act[1];

   logic [11:0] rec_ta   [2][512];
   logic [7:0]  rec_x    [2][512];
   logic [7:0]  rec_y    [2][512];
   int          rec_rise [2][512];
   int          rec_fall [2][512];
   int   rec_n     [2] = '{0, 0};
   int   done_cnt  [2] = '{0, 0};
   int   done_cyc  [2] = '{0, 0};
   int   busy_fall [2] = '{0, 0};
   int   stab_err  [2] = '{0, 0};
   int   ovl_err   [2] = '{0, 0};
   logic [8:0] max_addr [2] = '{9'd0, 9'd0};
   logic draw_p [2] = '{1'b0, 1'b0};
   logic busy_p [2] = '{1'b0, 1'b0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous map RAMs: data valid the cycle after the address.
   always @(posedge clk) begin
      map_data_s <= (map_addr_s < 9'd4)   ? mem_s[map_addr_s[1:0]] : 8'hFF;
      map_data_f <= (map_addr_f < 9'd300) ? mem_f[map_addr_f]      : 8'hFF;
   end

   // Drawer model: active ack_lat edges after draw rises, for act_len cycles.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         case (dr_phase[g])
            0: if (draw_w[g]) begin
                  if (ack_lat <= 1) begin
                     dr_act[g] <= 1'b1; dr_cnt[g] <= act_len; dr_phase[g] <= 2;
                  end else begin
                     dr_cnt[g] <= ack_lat - 1; dr_phase[g] <= 1;
                  end
               end
            1: if (dr_cnt[g] == 1) begin
                  dr_act[g] <= 1'b1; dr_cnt[g] <= act_len; dr_phase[g] <= 2;
               end else dr_cnt[g] <= dr_cnt[g] - 1;
            2: if (dr_cnt[g] == 1) begin
                  dr_act[g] <= 1'b0; dr_phase[g] <= 0;
               end else dr_cnt[g] <= dr_cnt[g] - 1;
            default: dr_phase[g] <= 0;
         endcase
      end
   end

   // Output monitor: logs draw requests, done pulses and stability.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (draw_w[g] && !draw_p[g]) begin
            if (dr_act[g]) ovl_err[g]++;
            rec_ta[g][rec_n[g]] = ta_w[g];
            rec_x[g][rec_n[g]]  = x_w[g];
            rec_y[g][rec_n[g]]  = y_w[g];
            rec_rise[g][rec_n[g]] = cyc;
            rec_fall[g][rec_n[g]] = -1;
            rec_n[g]++;
         end
         if (!draw_w[g] && draw_p[g] && rec_n[g] > 0) rec_fall[g][rec_n[g]-1] = cyc;
         if ((draw_w[g] || dr_act[g]) && rec_n[g] > 0 && !reset) begin
            if (ta_w[g] != rec_ta[g][rec_n[g]-1] || x_w[g] != rec_x[g][rec_n[g]-1] ||
                y_w[g] != rec_y[g][rec_n[g]-1]) stab_err[g]++;
         end
         if (done_w[g]) begin done_cnt[g]++; done_cyc[g] = cyc; end
         if (!busy_w[g] && busy_p[g]) busy_fall[g] = cyc;
         if (ma_w[g] > max_addr[g]) max_addr[g] = ma_w[g];
         draw_p[g] = draw_w[g];
         busy_p[g] = busy_w[g];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic start_pulse(input int g, output int e0);
      @(posedge clk); #1;
      if (g == 0) start_s = 1'b1; else start_f = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0; start_f = 1'b0;
      e0 = cyc;
   endtask

   task automatic wait_done(input int g, input int base, input int budget, input string nm);
      int k = 0;
      while (done_cnt[g] == base && k < budget) begin @(posedge clk); k++; end
      chk({nm, " done_within_budget"}, int'(done_cnt[g] != base), 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int g);
      int k = 0;
      while ((dr_phase[g] != 0 || dr_act[g]) && k < 200) begin @(posedge clk); k++; end
      chk("drawer_model_idle", dr_phase[g], 0);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int b_rec, b_done, b_stab, e0;
      for (int c = 0; c < 4; c++) mem_s[c] = v.idx[c];
      ack_lat = int'(v.a); act_len = int'(v.l);
      wait_idle(0);
      b_rec = rec_n[0]; b_done = done_cnt[0]; b_stab = stab_err[0];
      start_pulse(0, e0);
      wait_done(0, b_done, 2000, nm);
      chk({nm, " draws"}, rec_n[0] - b_rec, int'(v.n));
      for (int k = 0; k < int'(v.n); k++) begin
         chk($sformatf("%s d%0d tile_address", nm, k), int'(rec_ta[0][b_rec+k]), int'(v.ta[k]));
         chk($sformatf("%s d%0d x_pos", nm, k), int'(rec_x[0][b_rec+k]), int'(v.x[k]));
         chk($sformatf("%s d%0d y_pos", nm, k), int'(rec_y[0][b_rec+k]), int'(v.y[k]));
         chk($sformatf("%s d%0d rise", nm, k), rec_rise[0][b_rec+k] - e0, int'(v.rise[k]));
         chk($sformatf("%s d%0d draw_width", nm, k),
             rec_fall[0][b_rec+k] - rec_rise[0][b_rec+k], int'(v.a) + 1);
      end
      chk({nm, " done_pulses"}, done_cnt[0] - b_done, 1);
      chk({nm, " done_cycle"}, done_cyc[0] - e0, int'(v.done_off));
      chk({nm, " busy_fall"}, busy_fall[0] - e0, int'(v.done_off) + 1);
      chk({nm, " addr_stable"}, stab_err[0] - b_stab, 0);
   endtask

   initial begin
      int e0, b_rec, b_done, k;
      reset = 1'b1; start_s = 1'b0; start_f = 1'b0; hold_act = 1'b0;
      ack_lat = 1; act_len = 10;
      for (int i = 0; i < 4; i++) mem_s[i] = 8'hFF;
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++) mem_f[r*20+c] = 8'((r + c) % 21);

      vecs[0] = '{idx: {8'd3, 8'd2, 8'd1, 8'd0}, a: 8'd1, l: 8'd10, n: 4'd4,
                  ta: {12'd576, 12'd384, 12'd192, 12'd0}, x: {8'd8, 8'd0, 8'd8, 8'd0},
                  y: {8'd8, 8'd8, 8'd0, 8'd0}, rise: {8'd47, 8'd32, 8'd17, 8'd2}, done_off: 8'd60};
      vecs[1] = '{idx: {8'd20, 8'd21, 8'hFF, 8'd5}, a: 8'd1, l: 8'd10, n: 4'd2,
                  ta: {12'd0, 12'd0, 12'd3840, 12'd960}, x: {8'd0, 8'd0, 8'd8, 8'd0},
                  y: {8'd0, 8'd0, 8'd8, 8'd0}, rise: {8'd0, 8'd0, 8'd23, 8'd2}, done_off: 8'd36};
      vecs[2] = '{idx: {8'd3, 8'hFF, 8'd0, 8'd7}, a: 8'd7, l: 8'd10, n: 4'd3,
                  ta: {12'd0, 12'd576, 12'd0, 12'd1344}, x: {8'd0, 8'd8, 8'd8, 8'd0},
                  y: {8'd0, 8'd8, 8'd0, 8'd0}, rise: {8'd0, 8'd47, 8'd23, 8'd2}, done_off: 8'd66};
      vecs[3] = '{idx: {8'd1, 8'd1, 8'd1, 8'd1}, a: 8'd1, l: 8'd1, n: 4'd4,
                  ta: {12'd192, 12'd192, 12'd192, 12'd192}, x: {8'd8, 8'd0, 8'd8, 8'd0},
                  y: {8'd8, 8'd8, 8'd0, 8'd0}, rise: {8'd20, 8'd14, 8'd8, 8'd2}, done_off: 8'd24};
      vecs[4] = '{idx: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, a: 8'd1, l: 8'd1, n: 4'd0,
                  ta: '0, x: '0, y: '0, rise: '0, done_off: 8'd12};

      repeat (3) @(posedge clk);
      #1;
      chk("reset map_addr", int'(map_addr_s), 0);
      chk("reset tile_address", int'(ta_s), 0);
      chk("reset x_pos", int'(x_s), 0);
      chk("reset y_pos", int'(y_s), 0);
      chk("reset draw", int'(draw_s), 0);
      chk("reset busy", int'(busy_s), 0);
      chk("reset done", int'(done_s), 0);
      chk("reset busy_full", int'(busy_f), 0);
      reset = 1'b0;

      for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Drawer already busy when ISSUE is entered: one-cycle draw.
      for (int c = 0; c < 4; c++) mem_s[c] = 8'd4;
      ack_lat = 1; act_len = 2;
      wait_idle(0);
      b_rec = rec_n[0]; b_done = done_cnt[0];
      hold_act = 1'b1;
      start_pulse(0, e0);
      k = 0;
      while (rec_n[0] == b_rec && k < 50) begin @(posedge clk); k++; end
      repeat (4) @(posedge clk);
      #1 hold_act = 1'b0;
      wait_done(0, b_done, 500, "hold");
      chk("hold first_width", rec_fall[0][b_rec] - rec_rise[0][b_rec], 1);
      chk("hold first_tile_address", int'(rec_ta[0][b_rec]), 768);
      chk("hold draws", rec_n[0] - b_rec, 4);
      chk("hold done_pulses", done_cnt[0] - b_done, 1);

      // Reset while the drawer is working on cell 2.
      for (int c = 0; c < 4; c++) mem_s[c] = 8'(c);
      ack_lat = 1; act_len = 10;
      wait_idle(0);
      b_rec = rec_n[0]; b_done = done_cnt[0];
      start_pulse(0, e0);
      k = 0;
      while (rec_n[0] < b_rec + 2 && k < 100) begin @(posedge clk); k++; end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset draw", int'(draw_s), 0);
      chk("midreset busy", int'(busy_s), 0);
      chk("midreset done", int'(done_s), 0);
      chk("midreset map_addr", int'(map_addr_s), 0);
      chk("midreset tile_address", int'(ta_s), 0);
      chk("midreset x_pos", int'(x_s), 0);
      chk("midreset y_pos", int'(y_s), 0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("midreset no_more_draws", rec_n[0] - b_rec, 2);
      chk("midreset no_done", done_cnt[0] - b_done, 0);
      chk("midreset stays_idle", int'(busy_s), 0);
      run_vec(vecs[0], "restart");

      // Start pulsed while busy is ignored and not queued.
      wait_idle(0);
      b_rec = rec_n[0]; b_done = done_cnt[0];
      start_pulse(0, e0);
      repeat (4) @(posedge clk);
      #1 start_s = 1'b1;
      @(posedge clk); #1 start_s = 1'b0;
      wait_done(0, b_done, 500, "busy_start");
      repeat (20) @(posedge clk);
      #1;
      chk("busy_start draws", rec_n[0] - b_rec, 4);
      chk("busy_start done_pulses", done_cnt[0] - b_done, 1);
      chk("busy_start idle_after", int'(busy_s), 0);
      chk("busy_start first_rise", rec_rise[0][b_rec] - e0, 2);

      // Full default 20x15 map.
      ack_lat = 1; act_len = 2;
      wait_idle(1);
      b_rec = rec_n[1]; b_done = done_cnt[1];
      start_pulse(1, e0);
      wait_done(1, b_done, 4000, "full");
      chk("full draws", rec_n[1] - b_rec, 300);
      k = 0;
      for (int i = 0; i < 300; i++) begin
         int r, c;
         r = i / 20; c = i % 20;
         if (int'(rec_ta[1][b_rec+i]) != ((r + c) % 21) * 192 ||
             int'(rec_x[1][b_rec+i]) != c * 8 || int'(rec_y[1][b_rec+i]) != r * 8) k++;
      end
      chk("full order_mismatches", k, 0);
      chk("full last tile_address", int'(rec_ta[1][b_rec+299]), 2304);
      chk("full last x_pos", int'(rec_x[1][b_rec+299]), 152);
      chk("full last y_pos", int'(rec_y[1][b_rec+299]), 112);
      chk("full done_pulses", done_cnt[1] - b_done, 1);
      chk("full max_map_addr", int'(max_addr[1]), 299);
      chk("small max_map_addr", int'(max_addr[0]), 3);
      chk("draw_while_active small", ovl_err[0], 0);
      chk("draw_while_active full", ovl_err[1], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
